uart_io_unit: RTL and testbench

- Responder end of the core's uart_go / uart_done handshake.
- The multicycle controller issues a send (rors=1) or receive (rors=0) request.
- Sends: this block serializes one byte onto txd in 8N1 format.
- Receives: this block returns the oldest byte from an RX FIFO that a UART deserializer fills from rxd. It sits between the controller/datapath and the board UART pins.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_core.sv | 133 +++++++++++++
 rtl/uart_io_unit.sv | 180 ++++++++++++++++++
 tb/tb_uart_io_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART request/response unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        RECV_WAIT,
        DONE
    } uio_state_t;

    localparam logic RORS_RECV = 1'b0;
    localparam logic RORS_SEND = 1'b1;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART deserializer with a 2-FF input synchronizer and a start-bit glitch filter.
// Latency: o_valid/o_frame_err pulse one cycle after the mid-stop-bit sample.
// Backpressure: none; every good frame produces a one-cycle o_valid pulse.
module uart_rx_core #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_frame_err
);
    import uart_pkg::*;

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [1:0]    r_sync;
    logic          r_rxd_prev;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          r_frame_err;

    logic w_rxs;
    logic w_fall;
    logic w_half;
    logic w_full;
    logic w_cnt_clr;
    logic w_shift_en;
    logic w_push;
    logic w_ferr;

    assign w_rxs  = r_sync[1];
    assign w_fall = r_rxd_prev & ~w_rxs;
    assign w_half = (r_cnt == HALF_M1);
    assign w_full = (r_cnt == FULL_M1);

    assign o_byte      = r_shift;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;

    // Frame state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame sequencing: start re-check at half bit, then full-bit samples for data and stop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        unique case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (w_half) begin
                    w_cnt_clr   = 1'b1;
                    // A line that is high again at mid-start was only a glitch.
                    w_state_nxt = w_rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_full) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == BW'(UART_DATA_BITS - 1)) begin
                        w_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (w_full) begin
                    w_push      = w_rxs;
                    w_ferr      = ~w_rxs;
                    w_state_nxt = RX_IDLE;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    // Synchronizer, bit timer, shift register and result pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync      <= 2'b11;
            r_rxd_prev  <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], rxd};
            r_rxd_prev  <= w_rxs;
            r_cnt       <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            r_valid     <= w_push;
            r_frame_err <= w_ferr;
            if (r_state == RX_START) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {w_rxs, r_shift[7:1]};
            end
        end
    end

endmodule

// File: rtl/uart_io_unit.sv
// Responder for the controller's uart_go/uart_done handshake: 8N1 transmit or FIFO'd receive.
// Latency: send done at 10*CLK_PER_BIT+1 cycles after go; receive done 2 cycles after go or after the push.
// Backpressure: go is ignored while busy; RX bytes arriving to a full FIFO are dropped and flagged.
module uart_io_unit #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_go,
    input  logic        rors,
    input  logic [7:0]  wdata,
    output logic        uart_done,
    output logic [31:0] rdata,
    output logic        txd,
    input  logic        rxd,
    output logic        rx_overrun,
    output logic        rx_frame_err
);
    import uart_pkg::*;

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    uio_state_t    r_state;
    uio_state_t    w_state_nxt;

    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic [8:0]    r_tx_sr;
    logic          r_txd;

    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [31:0]   r_rdata;
    logic          r_overrun;
    logic          r_frame_err;

    logic [7:0]    w_rx_byte;
    logic          w_rx_valid;
    logic          w_rx_ferr;
    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic          w_pop;
    logic          w_tx_load;
    logic          w_tx_bit_end;
    logic          w_tx_last;

    uart_rx_core #(
        .CLK_PER_BIT(CLK_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .rstn        (rstn),
        .rxd         (rxd),
        .o_byte      (w_rx_byte),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_rx_ferr)
    );

    // Occupancy comes from registered pointers, so a pop never sees a same-cycle push.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == (AW + 1)'(FIFO_DEPTH));
    assign w_push  = w_rx_valid & (~w_full | w_pop);
    assign w_drop  = w_rx_valid & w_full & ~w_pop;

    // Bit slot 0 is the start bit, 1..8 data, 9 the stop bit.
    assign w_tx_bit_end = (r_tx_cnt == CW'(CLK_PER_BIT - 1));
    assign w_tx_last    = w_tx_bit_end & (r_tx_bit == 4'(UART_DATA_BITS + 1));

    assign uart_done    = (r_state == DONE);
    assign rdata        = r_rdata;
    assign txd          = r_txd;
    assign rx_overrun   = r_overrun;
    assign rx_frame_err = r_frame_err;

    // Handshake state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request decode, send completion and receive pop.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_load   = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (uart_go) begin
                    if (rors == RORS_SEND) begin
                        w_tx_load   = 1'b1;
                        w_state_nxt = SEND;
                    end else begin
                        w_state_nxt = RECV_WAIT;
                    end
                end
            end
            SEND: begin
                if (w_tx_last) begin
                    w_state_nxt = DONE;
                end
            end
            RECV_WAIT: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Transmit shifter: txd is registered so the start bit appears the cycle after go.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_txd    <= 1'b1;
            r_tx_sr  <= '1;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
        end else if (w_tx_load) begin
            r_txd    <= 1'b0;
            r_tx_sr  <= {1'b1, wdata};
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
        end else if (r_state == SEND) begin
            if (w_tx_bit_end) begin
                r_tx_cnt <= '0;
                if (!w_tx_last) begin
                    r_tx_bit <= r_tx_bit + 1'b1;
                    r_txd    <= r_tx_sr[0];
                    r_tx_sr  <= {1'b1, r_tx_sr[8:1]};
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_rx_byte;
        end
    end

    // FIFO pointers, read-data register and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rdata     <= '0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rdata  <= {24'h0, r_mem[r_rd_ptr[AW-1:0]]};
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_rx_ferr) begin
                r_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_io_unit.sv
// Self-checking bench for uart_io_unit with a queue-based model of sends, receives and flags.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_io_unit;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic        clk     = 1'b0;
    logic        rstn    = 1'b0;
    logic        uart_go = 1'b0;
    logic        rors    = 1'b0;
    logic [7:0]  wdata   = 8'h00;
    logic        rxd     = 1'b1;
    logic        uart_done;
    logic [31:0] rdata;
    logic        txd;
    logic        rx_overrun;
    logic        rx_frame_err;

    uart_io_unit #(
        .CLK_PER_BIT(CPB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .uart_go      (uart_go),
        .rors         (rors),
        .wdata        (wdata),
        .uart_done    (uart_done),
        .rdata        (rdata),
        .txd          (txd),
        .rxd          (rxd),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    logic [7:0]  q[$];
    bit          m_ovr        = 1'b0;
    bit          m_ferr       = 1'b0;
    logic [31:0] m_rdata      = 32'h0;
    bit          tx_on        = 1'b0;
    int          tx_go        = 0;
    logic [9:0]  tx_frame     = 10'h3FF;
    bit          win_on       = 1'b0;
    int          win_lo       = 0;
    int          win_hi       = 0;
    logic [31:0] win_rdata    = 32'h0;
    bit          recv_waiting = 1'b0;
    bit          rx_busy      = 1'b0;
    logic        exp_txd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_chk(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_done(input int lo, input int hi, input logic [31:0] rd);
        win_on    = 1'b1;
        win_lo    = lo;
        win_hi    = hi;
        win_rdata = rd;
    endtask

    task automatic pulse_go(input logic r, input logic [7:0] d);
        uart_go = 1'b1;
        rors    = r;
        wdata   = d;
        tick();
        uart_go = 1'b0;
        rors    = 1'($urandom);
        wdata   = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 * CPB && win_on; i++) tick();
        if (win_on) begin
            fail_chk("uart_done_timeout");
            win_on = 1'b0;
        end
    endtask

    task automatic start_send(input logic [7:0] b);
        tx_on    = 1'b1;
        tx_go    = cyc;
        tx_frame = {1'b1, b, 1'b0};
        expect_done(cyc + 10 * CPB + 1, cyc + 10 * CPB + 1, m_rdata);
        pulse_go(1'b1, b);
    endtask

    task automatic do_send(input logic [7:0] b, input bit noise);
        start_send(b);
        if (noise) begin
            ticks($urandom_range(1, 10 * CPB - 3));
            pulse_go(1'($urandom), 8'($urandom));
        end
        wait_idle();
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit stop_ok);
        int s;
        bit consumed;
        consumed = 1'b0;
        rx_busy  = 1'b1;
        s        = cyc;
        if (stop_ok && recv_waiting) begin
            expect_done(s + 9 * CPB + CPB / 2, s + 10 * CPB, {24'h0, b});
            recv_waiting = 1'b0;
            consumed     = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            rxd = (i == 0) ? 1'b0 : (i == 9) ? stop_ok : b[i-1];
            ticks(CPB);
        end
        rxd = 1'b1;
        if (!stop_ok) begin
            m_ferr = 1'b1;
        end else if (!consumed) begin
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovr = 1'b1;
        end
        rx_busy = 1'b0;
    endtask

    task automatic do_recv(input logic [7:0] fb);
        logic [7:0] h;
        if (q.size() > 0) begin
            h = q.pop_front();
            expect_done(cyc + 2, cyc + 2, {24'h0, h});
            pulse_go(1'b0, 8'($urandom));
        end else begin
            recv_waiting = 1'b1;
            pulse_go(1'b0, 8'($urandom));
            ticks($urandom_range(0, 10));
            pulse_go(1'b1, 8'($urandom));
            ticks(2);
            drive_frame(fb, 1'b1);
        end
        wait_idle();
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (rstn) begin
            exp_txd = 1'b1;
            if (tx_on && cyc > tx_go && cyc <= tx_go + 10 * CPB)
                exp_txd = tx_frame[(cyc - tx_go - 1) / CPB];
            chk("txd", 32'(txd), 32'(exp_txd));
            if (uart_done) begin
                if (win_on && cyc >= win_lo && cyc <= win_hi) begin
                    chk("rdata_at_done", rdata, win_rdata);
                    m_rdata = win_rdata;
                    win_on  = 1'b0;
                    tx_on   = 1'b0;
                end else begin
                    fail_chk("uart_done_unexpected");
                end
            end else begin
                if (win_on && cyc > win_hi) begin
                    fail_chk("uart_done_missing");
                    win_on = 1'b0;
                end
                chk("rdata_hold", rdata, m_rdata);
            end
            if (!rx_busy) begin
                chk("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
                chk("rx_frame_err", 32'(rx_frame_err), 32'(m_ferr));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        int g;
        int op;

        // Reset state
        ticks(3);
        chk("reset_txd", 32'(txd), 32'h1);
        chk("reset_done", 32'(uart_done), 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_ovr", 32'(rx_overrun), 32'h0);
        chk("reset_ferr", 32'(rx_frame_err), 32'h0);
        rstn = 1'b1;
        ticks(3);

        // Send A5 with hand-computed bit pattern and completion cycle
        g = cyc;
        start_send(8'hA5);
        ticks(CPB / 2);
        for (int k = 0; k < 10; k++) begin
            chk("a5_bit", 32'(txd), a5_bits[k]);
            if (k < 9) ticks(CPB);
        end
        ticks(g + 160 - cyc);
        chk("a5_done_early", 32'(uart_done), 32'h0);
        tick();
        chk("a5_done_161", 32'(uart_done), 32'h1);
        wait_idle();
        ticks(2);

        // Receive with data already queued
        drive_frame(8'h3C, 1'b1);
        ticks(3);
        do_recv(8'h00);
        chk("rdata_3c", rdata, 32'h0000003C);

        // Receive waiting on an empty FIFO, with an ignored go in between
        ticks(5);
        do_recv(8'h7E);
        chk("rdata_7e", rdata, 32'h0000007E);

        // Overrun: five frames into a four-deep FIFO
        for (int k = 1; k <= 5; k++) drive_frame(8'(k), 1'b1);
        ticks(2);
        chk("ovr_set", 32'(rx_overrun), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            do_recv(8'h00);
            chk("ovr_pop", rdata, 32'(k));
        end
        do_recv(8'h06);
        chk("ovr_fifth_waits", rdata, 32'h00000006);

        // Framing error then a start glitch; neither may reach the FIFO
        drive_frame(8'h55, 1'b0);
        ticks(2);
        chk("ferr_set", 32'(rx_frame_err), 32'h1);
        rx_busy = 1'b1;
        rxd     = 1'b0;
        ticks(4);
        rxd     = 1'b1;
        ticks(2 * CPB);
        rx_busy = 1'b0;
        do_recv(8'h99);
        chk("rdata_after_glitch", rdata, 32'h00000099);

        // Reset in the middle of a send
        start_send(8'hFF);
        ticks(49);
        rstn    = 1'b0;
        tx_on   = 1'b0;
        win_on  = 1'b0;
        q.delete();
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        m_rdata = 32'h0;
        #1;
        chk("rst_mid_txd", 32'(txd), 32'h1);
        chk("rst_mid_done", 32'(uart_done), 32'h0);
        chk("rst_mid_ovr", 32'(rx_overrun), 32'h0);
        chk("rst_mid_rdata", rdata, 32'h0);
        ticks(3);
        rstn = 1'b1;
        ticks(2);
        do_send(8'h00, 1'b0);

        // Randomized mix of sends, frames and receives
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0:       do_send(8'($urandom), 1'b1);
                1:       drive_frame(8'($urandom), $urandom_range(0, 7) != 0);
                2:       drive_frame(8'($urandom), 1'b1);
                default: do_recv(8'($urandom));
            endcase
            ticks($urandom_range(0, 20));
        end
        while (q.size() > 0) do_recv(8'h00);
        ticks(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
